// File: rtl/sram_ctrl.sv
// sram_ctrl: sequences single-word requests into registered nCS/nOE/nWE strobes for an async SRAM/ROM.
// Define SRAM_CTRL_WRVERIFY_EN to add a readback-verify phase after every write and the sticky err output.
`timescale 1ns/1ps
module sram_ctrl #(
  parameter int ABITS    = 8,
  parameter int DBITS    = 4,
  parameter int RD_WAIT  = 2,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 2,
  parameter int WR_HOLD  = 1,
  parameter int TURN     = 1
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             req,
  input  logic             we,
  input  logic [ABITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  output logic             ready,
  output logic [DBITS-1:0] rdata,
  output logic             rvalid,
  output logic             wdone,
`ifdef SRAM_CTRL_WRVERIFY_EN
  output logic             err,
`endif
  output logic [ABITS-1:0] memA,
  inout  wire  [DBITS-1:0] memD,
  output logic             memNOE,
  output logic             memNWE,
  output logic             memNCS
);

  localparam int M1   = (RD_WAIT > WR_SETUP) ? RD_WAIT : WR_SETUP;
  localparam int M2   = (WR_PULSE > WR_HOLD) ? WR_PULSE : WR_HOLD;
  localparam int M3   = (TURN > 1) ? TURN : 1;
  localparam int M12  = (M1 > M2) ? M1 : M2;
  localparam int MAXP = (M12 > M3) ? M12 : M3;
  localparam int CW   = $clog2(MAXP + 1);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t RD_LD = cnt_t'(RD_WAIT - 1);
  localparam cnt_t WS_LD = cnt_t'(WR_SETUP - 1);
  localparam cnt_t WP_LD = cnt_t'(WR_PULSE - 1);
  localparam cnt_t WH_LD = cnt_t'(WR_HOLD - 1);
  localparam cnt_t TU_LD = cnt_t'((TURN > 0) ? TURN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_WSETUP, S_WPULSE, S_WHOLD, S_RACC, S_TURN
`ifdef SRAM_CTRL_WRVERIFY_EN
    , S_VERIFY
`endif
  } state_t;

  state_t           state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [ABITS-1:0] mema_q, mema_d;
  logic [DBITS-1:0] wd_q, wd_d;
  logic             doe_q, doe_d;
  logic             ncs_q, ncs_d, nwe_q, nwe_d, noe_q, noe_d;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d, wdone_q, wdone_d;
`ifdef SRAM_CTRL_WRVERIFY_EN
  logic             err_q, err_d;
`endif

  always_comb begin
    // NOTE: every variable gets its default first so no path through the case infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    mema_d   = mema_q;
    wd_d     = wd_q;
    doe_d    = doe_q;
    ncs_d    = ncs_q;
    nwe_d    = nwe_q;
    noe_d    = noe_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;
`ifdef SRAM_CTRL_WRVERIFY_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      S_IDLE: if (req) begin
        mema_d  = addr;
        wd_d    = wdata;
        ready_d = 1'b0;
        ncs_d   = 1'b0;
        if (we) begin
          state_d = S_WSETUP;
          cnt_d   = WS_LD;
          doe_d   = 1'b1;
        end else begin
          state_d = S_RACC;
          cnt_d   = RD_LD;
          noe_d   = 1'b0;
        end
      end
      S_WSETUP: if (cnt_q == '0) begin
        state_d = S_WPULSE;
        cnt_d   = WP_LD;
        nwe_d   = 1'b0;
      end else cnt_d = cnt_q - 1'b1;
      S_WPULSE: if (cnt_q == '0) begin
        state_d = S_WHOLD;
        cnt_d   = WH_LD;
        nwe_d   = 1'b1;
      end else cnt_d = cnt_q - 1'b1;
      S_WHOLD: if (cnt_q == '0) begin
        doe_d = 1'b0;
`ifdef SRAM_CTRL_WRVERIFY_EN
        // nCS stays low; the readback reuses the read strobe timing
        state_d = S_VERIFY;
        cnt_d   = RD_LD;
        noe_d   = 1'b0;
`else
        state_d = S_IDLE;
        ready_d = 1'b1;
        ncs_d   = 1'b1;
        wdone_d = 1'b1;
`endif
      end else cnt_d = cnt_q - 1'b1;
      S_RACC: if (cnt_q == '0) begin
        rdata_d  = memD;
        rvalid_d = 1'b1;
        ncs_d    = 1'b1;
        noe_d    = 1'b1;
        if (TURN == 0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          state_d = S_TURN;
          cnt_d   = TU_LD;
        end
      end else cnt_d = cnt_q - 1'b1;
`ifdef SRAM_CTRL_WRVERIFY_EN
      S_VERIFY: if (cnt_q == '0) begin
        // An X/Z compare is not true, so the else branch also flags undriven bits in simulation
        if (memD == wd_q) err_d = err_q;
        else              err_d = 1'b1;
        wdone_d = 1'b1;
        ncs_d   = 1'b1;
        noe_d   = 1'b1;
        if (TURN == 0) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          state_d = S_TURN;
          cnt_d   = TU_LD;
        end
      end else cnt_d = cnt_q - 1'b1;
`endif
      S_TURN: if (cnt_q == '0) begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end else cnt_d = cnt_q - 1'b1;
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        doe_d   = 1'b0;
        ncs_d   = 1'b1;
        nwe_d   = 1'b1;
        noe_d   = 1'b1;
      end
    endcase
  end

  // Async reset lifts every strobe and releases memD without waiting for a clock edge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      mema_q   <= '0;
      wd_q     <= '0;
      doe_q    <= 1'b0;
      ncs_q    <= 1'b1;
      nwe_q    <= 1'b1;
      noe_q    <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
`ifdef SRAM_CTRL_WRVERIFY_EN
      err_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      mema_q   <= mema_d;
      wd_q     <= wd_d;
      doe_q    <= doe_d;
      ncs_q    <= ncs_d;
      nwe_q    <= nwe_d;
      noe_q    <= noe_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
`ifdef SRAM_CTRL_WRVERIFY_EN
      err_q    <= err_d;
`endif
    end
  end

  assign ready  = ready_q;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign wdone  = wdone_q;
`ifdef SRAM_CTRL_WRVERIFY_EN
  assign err    = err_q;
`endif
  assign memA   = mema_q;
  assign memNCS = ncs_q;
  assign memNWE = nwe_q;
  assign memNOE = noe_q;
  assign memD   = doe_q ? wd_q : {DBITS{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed vectors plus hand-written strobe sequences for sram_ctrl, against a small async-SRAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_sram_ctrl;
`ifdef SRAM_CTRL_WRVERIFY_EN
  localparam int WLAT = 6;
`else
  localparam int WLAT = 4;
`endif
  localparam int RLAT = 2;

  logic       clk = 1'b0, nReset = 1'b0, req = 1'b0, we = 1'b0;
  logic [7:0] addr = '0;
  logic [3:0] wdata = '0;
  logic       ready, rvalid, wdone, memNOE, memNWE, memNCS;
  logic [3:0] rdata;
  logic [7:0] memA;
  wire  [3:0] memD;
`ifdef SRAM_CTRL_WRVERIFY_EN
  logic       err;
`endif

  int n_tests = 0, n_fail = 0;
  int nwe_falls = 0, noe_falls = 0, wdone_cnt = 0, rvalid_cnt = 0;

  sram_ctrl dut (
    .clk(clk), .nReset(nReset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rvalid(rvalid), .wdone(wdone),
`ifdef SRAM_CTRL_WRVERIFY_EN
    .err(err),
`endif
    .memA(memA), .memD(memD), .memNOE(memNOE), .memNWE(memNWE), .memNCS(memNCS)
  );

  always #5 clk = ~clk;

  // Async SRAM model: drives the bus while selected and output-enabled, writes on the rising nWE edge.
  logic [3:0] mem [256];
  logic       corrupt_en = 1'b0;
  logic [7:0] corrupt_addr = 8'h40;
  logic [3:0] mem_rd;
  assign mem_rd = (corrupt_en && memA == corrupt_addr) ? (mem[memA] ^ 4'h1) : mem[memA];
  assign memD   = (!memNCS && !memNOE) ? mem_rd : 4'bzzzz;
  always @(posedge memNWE) if (!memNCS && nReset) mem[memA] <= memD;
  always @(negedge memNWE) nwe_falls++;
  always @(negedge memNOE) noe_falls++;
  always @(negedge clk) begin
    if (wdone)  wdone_cnt++;
    if (rvalid) rvalid_cnt++;
  end

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [3:0] d;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int i;
    for (i = 0; i < 20 && !ready; i++) @(negedge clk);
    if (!ready) check("ready timeout", 32'(ready), 32'd1);
  endtask

  // Waits, from a falling edge just after the accept edge, for wdone/rvalid; lat counts clock edges since accept.
  task automatic wait_done(input logic w, output int lat, output logic [3:0] rd);
    lat = -1;
    rd  = '0;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) @(negedge clk);
      if (w ? wdone : rvalid) begin
        lat = i;
        rd  = rdata;
        break;
      end
    end
  endtask

  task automatic do_op(input logic w, input logic [7:0] a, input logic [3:0] d,
                       output int lat, output logic [3:0] rd);
    wait_ready();
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    wait_done(w, lat, rd);
  endtask

  initial begin
    int lat, snap_nwe, snap_noe, snap_wd, snap_rv;
    logic [3:0] rd;
    logic [2:0] t1_exp [5];

    // Reset state
    repeat (3) @(negedge clk);
    check("rst ready", 32'(ready), 1);
    check("rst strobes", 32'({memNCS, memNWE, memNOE}), 3'b111);
    check("rst memA", 32'(memA), 0);
    check("rst rdata", 32'(rdata), 0);
    check("rst rvalid", 32'(rvalid), 0);
    check("rst wdone", 32'(wdone), 0);
`ifdef SRAM_CTRL_WRVERIFY_EN
    check("rst err", 32'(err), 0);
`endif
    nReset = 1'b1;
    @(negedge clk);

    // Test 1: write 0xA to 0x3C, strobe shape {nCS,nWE,nOE} per cycle after accept
    t1_exp[0] = 3'b011; t1_exp[1] = 3'b001; t1_exp[2] = 3'b001; t1_exp[3] = 3'b011;
`ifdef SRAM_CTRL_WRVERIFY_EN
    t1_exp[4] = 3'b010;
`else
    t1_exp[4] = 3'b111;
`endif
    wait_ready();
    req = 1'b1; we = 1'b1; addr = 8'h3C; wdata = 4'hA;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("t1 ready drop", 32'(ready), 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("t1 strobes c%0d", i), 32'({memNCS, memNWE, memNOE}), 32'(t1_exp[i]));
      if (i < 4) begin
        check($sformatf("t1 memA c%0d", i), 32'(memA), 32'h3C);
        check($sformatf("t1 memD c%0d", i), 32'(memD), 32'hA);
      end
      if (i == 4) begin
        wait_done(1'b1, lat, rd);
        check("t1 write latency", 32'(lat + 4), 32'(WLAT));
      end
    end

    // Test 2: read it back
    do_op(1'b0, 8'h3C, 4'h0, lat, rd);
    check("t2 read latency", 32'(lat), 32'(RLAT));
    check("t2 rdata", 32'(rd), 32'hA);

    // Directed vectors
    vecs[0] = '{1'b1, 8'h10, 4'h3, 4'h0};
    vecs[1] = '{1'b1, 8'h00, 4'hF, 4'h0};
    vecs[2] = '{1'b1, 8'hFF, 4'h1, 4'h0};
    vecs[3] = '{1'b0, 8'hFF, 4'h0, 4'h1};
    vecs[4] = '{1'b0, 8'h00, 4'h0, 4'hF};
    vecs[5] = '{1'b1, 8'h55, 4'h0, 4'h0};
    vecs[6] = '{1'b0, 8'h55, 4'h0, 4'h0};
    vecs[7] = '{1'b0, 8'h10, 4'h0, 4'h3};
    vecs[8] = '{1'b0, 8'h3C, 4'h0, 4'hA};
    for (int v = 0; v < 9; v++) begin
      do_op(vecs[v].w, vecs[v].a, vecs[v].d, lat, rd);
      check($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].w ? WLAT : RLAT));
      if (!vecs[v].w) check($sformatf("vec%0d rdata", v), 32'(rd), 32'(vecs[v].exp));
    end

    // Test 3: read 0x10 then write 0x11 with req held high
    wait_ready();
    req = 1'b1; we = 1'b0; addr = 8'h10;
    @(posedge clk);
    @(negedge clk);
    we = 1'b1; addr = 8'h11; wdata = 4'h5;
    check("t3 rd strobes", 32'({memNCS, memNWE, memNOE}), 3'b010);
    @(negedge clk);
    @(negedge clk);
    check("t3 rvalid", 32'(rvalid), 1);
    check("t3 rdata", 32'(rdata), 32'h3);
    check("t3 turn strobes", 32'({memNCS, memNWE, memNOE}), 3'b111);
    check("t3 turn ready", 32'(ready), 0);
    @(negedge clk);
    check("t3 ready back", 32'(ready), 1);
    check("t3 idle strobes", 32'({memNCS, memNWE, memNOE}), 3'b111);
    @(negedge clk);
    req = 1'b0;
    check("t3 wsetup strobes", 32'({memNCS, memNWE, memNOE}), 3'b011);
    check("t3 wr memA", 32'(memA), 32'h11);
    check("t3 wr memD", 32'(memD), 32'h5);
    wait_done(1'b1, lat, rd);
    check("t3 write latency", 32'(lat), 32'(WLAT));
    do_op(1'b0, 8'h11, 4'h0, lat, rd);
    check("t3 readback", 32'(rd), 32'h5);

    // Test 4: reset during the write pulse
    repeat (2) @(negedge clk);
    snap_wd = wdone_cnt;
    wait_ready();
    req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 4'h6;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("t4 in pulse", 32'(memNWE), 0);
    #2 nReset = 1'b0;
    #1;
    check("t4 async strobes", 32'({memNCS, memNWE, memNOE}), 3'b111);
    check("t4 async ready", 32'(ready), 1);
    @(posedge clk);
    @(negedge clk);
    nReset = 1'b1;
    repeat (8) @(negedge clk);
    check("t4 ready after", 32'(ready), 1);
    check("t4 no wdone", 32'(wdone_cnt - snap_wd), 0);

    // Test 5: req toggled while busy must not start another access
    repeat (2) @(negedge clk);
    snap_nwe = nwe_falls; snap_noe = noe_falls; snap_wd = wdone_cnt; snap_rv = rvalid_cnt;
    wait_ready();
    req = 1'b1; we = 1'b1; addr = 8'h30; wdata = 4'h9;
    @(posedge clk);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 8'h31;
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (12) @(negedge clk);
    check("t5 nWE strobes", 32'(nwe_falls - snap_nwe), 1);
`ifdef SRAM_CTRL_WRVERIFY_EN
    check("t5 nOE strobes", 32'(noe_falls - snap_noe), 1);
`else
    check("t5 nOE strobes", 32'(noe_falls - snap_noe), 0);
`endif
    check("t5 wdone pulses", 32'(wdone_cnt - snap_wd), 1);
    check("t5 rvalid pulses", 32'(rvalid_cnt - snap_rv), 0);
    check("t5 mem content", 32'(mem[8'h30]), 32'h9);

`ifdef SRAM_CTRL_WRVERIFY_EN
    // Test 6: readback of 0x40 is corrupted by the model, err must set and stick
    check("t6 err clear", 32'(err), 0);
    corrupt_en = 1'b1;
    do_op(1'b1, 8'h40, 4'h7, lat, rd);
    check("t6 latency", 32'(lat), 32'(WLAT));
    check("t6 err set", 32'(err), 1);
    do_op(1'b1, 8'h41, 4'h3, lat, rd);
    check("t6 err sticky", 32'(err), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
